// File: rtl/temp_alarm_controller_if.sv
// Signal bundle between the temperature detector side and the alarm controller.
interface temp_alarm_controller_if;
    logic       lowTempAbnormality;
    logic       highTempAbnormality;
    logic       alarmAck;
    logic       alarmActive;
    logic [1:0] alarmType;
    logic       alarmPending;
    logic [7:0] eventCount;

    modport master (
        output lowTempAbnormality, highTempAbnormality, alarmAck,
        input  alarmActive, alarmType, alarmPending, eventCount
    );

    modport slave (
        input  lowTempAbnormality, highTempAbnormality, alarmAck,
        output alarmActive, alarmType, alarmPending, eventCount
    );
endinterface

// File: rtl/temp_alarm_controller.sv
// Debounced temperature alarm with latched cause, acknowledged clear and event counter.
// Optional macro AUTO_CLEAR_EN: clear after the clean period without requiring an acknowledge.
module temp_alarm_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CLEAR_CYCLES    = 8,
    parameter int CNT_W           = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    temp_alarm_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_ALARM   = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       type_acc_q, type_acc_d;
    logic [1:0]       alarm_type_q, alarm_type_d;
    logic             ack_seen_q, ack_seen_d;
    logic [7:0]       event_count_q, event_count_d;
    logic             alarm_active_q, alarm_active_d;
    logic             alarm_pending_q, alarm_pending_d;

    logic [1:0]       flags_s;
    logic             abn_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             clear_ok_s;

    assign flags_s   = {bus.highTempAbnormality, bus.lowTempAbnormality};
    assign abn_s     = |flags_s;
    assign cnt_inc_s = (cnt_q >= CNT_W'(CLEAR_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);

    // The clear test looks at the count this edge produces, so the exit lands on the
    // CLEAR_CYCLES-th clean edge after the alarm condition went away.
`ifdef AUTO_CLEAR_EN
    assign clear_ok_s = (cnt_inc_s >= CNT_W'(CLEAR_CYCLES));
`else
    assign clear_ok_s = (cnt_inc_s >= CNT_W'(CLEAR_CYCLES)) && (ack_seen_q || bus.alarmAck);
`endif

    // Next-state and next-output computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        type_acc_d    = type_acc_q;
        alarm_type_d  = alarm_type_q;
        ack_seen_d    = ack_seen_q;
        event_count_d = event_count_q;

        case (state_q)
            ST_NORMAL: begin
                if (abn_s) begin
                    state_d    = ST_CONFIRM;
                    cnt_d      = CNT_W'(1);
                    type_acc_d = flags_s;
                end else begin
                    cnt_d      = '0;
                    type_acc_d = 2'b00;
                end
            end
            ST_CONFIRM: begin
                if (!abn_s) begin
                    state_d    = ST_NORMAL;
                    cnt_d      = '0;
                    type_acc_d = 2'b00;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d       = ST_ALARM;
                    cnt_d         = '0;
                    alarm_type_d  = type_acc_q | flags_s;
                    type_acc_d    = 2'b00;
                    event_count_d = sat_inc8(event_count_q);
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    type_acc_d = type_acc_q | flags_s;
                end
            end
            ST_ALARM: begin
                alarm_type_d = alarm_type_q | flags_s;
                if (bus.alarmAck) begin
                    ack_seen_d = 1'b1;
                end else begin
                    ack_seen_d = ack_seen_q;
                end
                if (!abn_s) begin
                    state_d = ST_RECOVER;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_ALARM;
                end
            end
            ST_RECOVER: begin
                if (bus.alarmAck) begin
                    ack_seen_d = 1'b1;
                end else begin
                    ack_seen_d = ack_seen_q;
                end
                if (abn_s) begin
                    state_d      = ST_ALARM;
                    cnt_d        = '0;
                    alarm_type_d = alarm_type_q | flags_s;
                end else if (clear_ok_s) begin
                    state_d      = ST_NORMAL;
                    cnt_d        = '0;
                    alarm_type_d = 2'b00;
                    ack_seen_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d      = ST_NORMAL;
                cnt_d        = '0;
                type_acc_d   = 2'b00;
                alarm_type_d = 2'b00;
                ack_seen_d   = 1'b0;
            end
        endcase

        alarm_active_d  = (state_d == ST_ALARM) || (state_d == ST_RECOVER);
        alarm_pending_d = (state_d == ST_CONFIRM);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_NORMAL;
            cnt_q           <= '0;
            type_acc_q      <= 2'b00;
            alarm_type_q    <= 2'b00;
            ack_seen_q      <= 1'b0;
            event_count_q   <= 8'd0;
            alarm_active_q  <= 1'b0;
            alarm_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            type_acc_q      <= type_acc_d;
            alarm_type_q    <= alarm_type_d;
            ack_seen_q      <= ack_seen_d;
            event_count_q   <= event_count_d;
            alarm_active_q  <= alarm_active_d;
            alarm_pending_q <= alarm_pending_d;
        end
    end

    assign bus.alarmActive  = alarm_active_q;
    assign bus.alarmType    = alarm_type_q;
    assign bus.alarmPending = alarm_pending_q;
    assign bus.eventCount   = event_count_q;

endmodule
